// File: rtl/cpu_ocimem_access_sequencer_pkg.sv
// rtl/cpu_ocimem_access_sequencer_pkg.sv - shared encodings for the monitor RAM access sequencer
package cpu_ocimem_access_sequencer_pkg;

   localparam int DATA_W = 32;

   localparam logic [1:0] OP_NOP      = 2'b00;
   localparam logic [1:0] OP_SET_ADDR = 2'b01;
   localparam logic [1:0] OP_WRITE    = 2'b10;
   localparam logic [1:0] OP_READ     = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WRITE     = 2'd1,
      ST_READ_WAIT = 2'd2,
      ST_RESP      = 2'd3
   } state_t;

endpackage

// File: rtl/ocimem_rd_latency_counter.sv
// rtl/ocimem_rd_latency_counter.sv - loadable down-counter timing the monitor RAM read latency
module ocimem_rd_latency_counter #(
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_value,
   input  logic             dec,
   output logic [CNT_W-1:0] count,
   output logic             expired
);

   // load wins over decrement; the count parks at zero once expired
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (dec && (count != '0)) begin
         count <= count - CNT_W'(1);
      end
   end

   assign expired = (count == '0);

endmodule

// File: rtl/cpu_ocimem_access_sequencer.sv
// rtl/cpu_ocimem_access_sequencer.sv - handshaked sequencer for debugger accesses to the monitor RAM
module cpu_ocimem_access_sequencer
   import cpu_ocimem_access_sequencer_pkg::*;
#(
   parameter int ADDR_W     = 8,
   parameter int RD_LATENCY = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [DATA_W-1:0] cmd_data,
   input  logic              debugack,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_data,
   output logic              resp_error,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_wr,
   output logic              mem_rd,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              monitor_ready,
   output logic              monitor_error
);

   localparam int               CNT_W = 2;
   localparam logic [CNT_W-1:0] LAT   = CNT_W'(RD_LATENCY);

   state_t              state;
   state_t              state_nxt;
   logic [ADDR_W-1:0]   addr;
   logic [ADDR_W-1:0]   addr_inc;
   logic [ADDR_W-1:0]   set_addr;
   logic [DATA_W-1:0]   wdata_q;
   logic                accept;
   logic                ram_op;
   logic                cnt_load;
   logic [CNT_W-1:0]    cnt;
   logic                cnt_expired;

   // word address rendered as a zero-extended byte address
   function automatic logic [DATA_W-1:0] byte_addr(input logic [ADDR_W-1:0] a);
      return DATA_W'({a, 2'b00});
   endfunction

   assign accept   = cmd_valid && cmd_ready;
   assign ram_op   = (cmd_op == OP_WRITE) || (cmd_op == OP_READ);
   assign addr_inc = addr + ADDR_W'(1);
   assign set_addr = cmd_data[ADDR_W+1:2];
   assign cnt_load = accept && (cmd_op == OP_READ) && debugack;

   assign cmd_ready     = (state == ST_IDLE);
   assign monitor_ready = cmd_ready;
   assign resp_valid    = (state == ST_RESP);
   assign mem_addr      = addr;
   assign mem_wdata     = wdata_q;
   // WRITE lasts one cycle; the read strobe is the first READ_WAIT cycle, before any decrement
   assign mem_wr        = (state == ST_WRITE);
   assign mem_rd        = (state == ST_READ_WAIT) && (cnt == LAT);

   ocimem_rd_latency_counter #(
      .CNT_W(CNT_W)
   ) u_rd_latency_counter (
      .clk        (clk),
      .reset      (reset),
      .load       (cnt_load),
      .load_value (LAT),
      .dec        (state == ST_READ_WAIT),
      .count      (cnt),
      .expired    (cnt_expired)
   );

   // state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // next-state decode; debugack only matters at accept
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               if (ram_op && debugack) begin
                  state_nxt = (cmd_op == OP_WRITE) ? ST_WRITE : ST_READ_WAIT;
               end else begin
                  state_nxt = ST_RESP;
               end
            end
         end
         ST_WRITE: begin
            state_nxt = ST_RESP;
         end
         ST_READ_WAIT: begin
            if (cnt_expired) begin
               state_nxt = ST_RESP;
            end
         end
         ST_RESP: begin
            if (resp_ready) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // address, write data, response and sticky error registers
   always_ff @(posedge clk) begin
      if (reset) begin
         addr          <= '0;
         wdata_q       <= '0;
         resp_data     <= '0;
         resp_error    <= 1'b0;
         monitor_error <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  resp_error <= 1'b0;
                  resp_data  <= byte_addr(addr);
                  if (cmd_op == OP_SET_ADDR) begin
                     addr          <= set_addr;
                     resp_data     <= byte_addr(set_addr);
                     monitor_error <= 1'b0;
                  end else if (ram_op && !debugack) begin
                     resp_error    <= 1'b1;
                     monitor_error <= 1'b1;
                  end else if (cmd_op == OP_WRITE) begin
                     wdata_q <= cmd_data;
                  end
               end
            end
            ST_WRITE: begin
               addr      <= addr_inc;
               resp_data <= byte_addr(addr_inc);
            end
            ST_READ_WAIT: begin
               if (cnt_expired) begin
                  addr      <= addr_inc;
                  resp_data <= mem_rdata;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_ocimem_access_sequencer.sv
// tb/tb_cpu_ocimem_access_sequencer.sv - self-checking bench for the monitor RAM access sequencer
module tb_cpu_ocimem_access_sequencer;
   import cpu_ocimem_access_sequencer_pkg::*;

   localparam int TB_LAT = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [31:0] cmd_data;
   logic        debugack;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_data;
   logic        resp_error;
   logic [7:0]  mem_addr;
   logic        mem_wr;
   logic        mem_rd;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        monitor_ready;
   logic        monitor_error;

   int errors = 0;
   int checks = 0;

   // environment RAM and strobe monitors
   logic [31:0] seed;
   logic [31:0] ram [256];
   logic [31:0] rd_pipe0, rd_pipe1;
   int          wr_cnt = 0;
   int          rd_cnt = 0;
   int          both_cnt = 0;
   logic [7:0]  last_wr_addr;
   logic [31:0] last_wr_data;

   // reference model state
   logic [7:0]  m_addr;
   logic        m_mon;
   logic [31:0] m_mem [256];

   always #5 clk = ~clk;

   cpu_ocimem_access_sequencer #(
      .ADDR_W(8),
      .RD_LATENCY(TB_LAT)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_op        (cmd_op),
      .cmd_data      (cmd_data),
      .debugack      (debugack),
      .resp_valid    (resp_valid),
      .resp_ready    (resp_ready),
      .resp_data     (resp_data),
      .resp_error    (resp_error),
      .mem_addr      (mem_addr),
      .mem_wr        (mem_wr),
      .mem_rd        (mem_rd),
      .mem_wdata     (mem_wdata),
      .mem_rdata     (mem_rdata),
      .monitor_ready (monitor_ready),
      .monitor_error (monitor_error)
   );

   function automatic logic [31:0] init_word(input int i);
      return (i * 32'h9E37_79B9) ^ seed;
   endfunction

   // RAM with TB_LAT-cycle read pipeline; garbage when no read is in flight
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
      end else if (mem_wr) begin
         ram[mem_addr] <= mem_wdata;
      end
      rd_pipe0 <= mem_rd ? ram[mem_addr] : $urandom;
      rd_pipe1 <= rd_pipe0;
   end
   assign mem_rdata = rd_pipe1;

   // strobe monitor
   always @(posedge clk) begin
      if (mem_wr) begin
         wr_cnt = wr_cnt + 1;
         last_wr_addr = mem_addr;
         last_wr_data = mem_wdata;
      end
      if (mem_rd) rd_cnt = rd_cnt + 1;
      if (mem_wr && mem_rd) both_cnt = both_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_addr = '0;
      m_mon  = 1'b0;
      for (int i = 0; i < 256; i++) m_mem[i] = init_word(i);
   endtask

   // one command through the handshake, with the response held for 'hold' cycles
   task automatic send(input logic [1:0] op, input logic [31:0] data, input logic dack, input int hold);
      logic [31:0] exp_data;
      logic        exp_err;
      int          exp_lat;
      int          exp_wr;
      int          exp_rd;
      logic [7:0]  exp_wa;
      int          wr0, rd0, lat;
      exp_err = 1'b0;
      exp_lat = 1;
      exp_wr  = 0;
      exp_rd  = 0;
      exp_wa  = m_addr;
      exp_data = '0;
      case (op)
         OP_SET_ADDR: begin
            m_addr = data[9:2];
            m_mon  = 1'b0;
         end
         OP_WRITE, OP_READ: begin
            if (!dack) begin
               exp_err = 1'b1;
               m_mon   = 1'b1;
            end else if (op == OP_WRITE) begin
               m_mem[m_addr] = data;
               m_addr  = m_addr + 8'd1;
               exp_lat = 2;
               exp_wr  = 1;
            end else begin
               exp_data = m_mem[m_addr];
               m_addr  = m_addr + 8'd1;
               exp_lat = TB_LAT + 2;
               exp_rd  = 1;
            end
         end
         default: begin
         end
      endcase
      if (!(op == OP_READ && dack)) exp_data = {22'd0, m_addr, 2'b00};

      @(negedge clk);
      chk("cmd_ready_idle", cmd_ready, 1);
      wr0 = wr_cnt;
      rd0 = rd_cnt;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = data;
      debugack  = dack;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cmd_op    = 2'($urandom);
      cmd_data  = $urandom;
      debugack  = 1'($urandom);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!resp_valid && lat < 20);
      chk("latency", lat, exp_lat);
      chk("resp_data", resp_data, exp_data);
      chk("resp_error", resp_error, exp_err);
      chk("monitor_error", monitor_error, m_mon);
      chk("mem_addr", mem_addr, m_addr);
      chk("wr_pulses", wr_cnt - wr0, exp_wr);
      chk("rd_pulses", rd_cnt - rd0, exp_rd);
      chk("monitor_ready_busy", monitor_ready, 0);
      if (exp_wr == 1) begin
         chk("wr_addr", last_wr_addr, exp_wa);
         chk("wr_data", last_wr_data, data);
      end
      for (int i = 0; i < hold; i++) begin
         resp_ready = 1'b0;
         @(negedge clk);
         chk("hold_valid", resp_valid, 1);
         chk("hold_data", resp_data, exp_data);
         chk("hold_cmd_ready", cmd_ready, 0);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      chk("post_valid", resp_valid, 0);
      chk("post_cmd_ready", cmd_ready, 1);
   endtask

   initial begin
      reset      = 1'b1;
      cmd_valid  = 1'b0;
      cmd_op     = OP_NOP;
      cmd_data   = '0;
      debugack   = 1'b0;
      resp_ready = 1'b0;
      seed       = $urandom;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);

      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_monitor_ready", monitor_ready, 1);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_data", resp_data, 0);
      chk("rst_resp_error", resp_error, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wr", mem_wr, 0);
      chk("rst_mem_rd", mem_rd, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_monitor_error", monitor_error, 0);

      // directed plan
      send(OP_SET_ADDR, 32'h0000_0010, 1'b0, 0);
      send(OP_WRITE, 32'hDEAD_BEEF, 1'b1, 0);
      send(OP_SET_ADDR, 32'h0000_0010, 1'b1, 0);
      send(OP_READ, 32'h0, 1'b1, 1);
      send(OP_WRITE, 32'h1234_5678, 1'b0, 0);
      send(OP_NOP, 32'h0, 1'b1, 0);
      send(OP_READ, 32'h0, 1'b0, 0);
      send(OP_SET_ADDR, 32'hFFFF_F3FF, 1'b0, 0);
      send(OP_WRITE, 32'hA5A5_0001, 1'b1, 0);
      send(OP_WRITE, 32'hA5A5_0002, 1'b1, 5);
      send(OP_SET_ADDR, 32'h0000_03FC, 1'b1, 0);
      send(OP_READ, 32'h0, 1'b1, 0);
      send(OP_READ, 32'h0, 1'b1, 2);

      // randomized traffic
      for (int n = 0; n < 80; n++) begin
         logic [1:0]  op;
         logic [31:0] d;
         op = 2'($urandom_range(0, 3));
         d  = $urandom;
         if (op == OP_SET_ADDR && $urandom_range(0, 3) == 0) d[9:2] = 8'hFE;
         send(op, d, ($urandom_range(0, 3) != 0), $urandom_range(0, 3));
      end

      // reset during READ_WAIT
      send(OP_SET_ADDR, 32'h0000_0100, 1'b1, 0);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = OP_READ;
      debugack  = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      @(negedge clk);
      chk("mid_rd_strobe", mem_rd, 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      chk("mid_rst_resp_valid", resp_valid, 0);
      chk("mid_rst_mem_rd", mem_rd, 0);
      chk("mid_rst_mem_addr", mem_addr, 0);
      chk("mid_rst_cmd_ready", cmd_ready, 1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("late_data_ignored", resp_valid, 0);
      end
      send(OP_NOP, 32'h0, 1'b0, 0);
      send(OP_READ, 32'h0, 1'b1, 0);

      chk("never_wr_and_rd", both_cnt, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
